// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One shift-add or restoring-subtract step per cycle on magnitudes, sign fix at the end.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic             is_div_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] mag_a_q;
    logic [WIDTH-1:0] mag_b_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             accept;
    logic             move_to;
    logic             signed_op;
    logic             in_neg_a;
    logic             in_neg_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = start && (state == IDLE) && !op[2];
    assign move_to   = start && (state == IDLE) && op[2] && !op[1];
    assign signed_op = !op[0];
    assign in_neg_a  = signed_op && a[WIDTH-1];
    assign in_neg_b  = signed_op && b[WIDTH-1];
    assign in_mag_a  = in_neg_a ? -a : a;
    assign in_mag_b  = in_neg_b ? -b : b;

    assign busy = (state != IDLE);

    // Multiply: {acc_hi, acc_lo} is the partial product, multiplier in acc_lo.
    assign mul_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mag_a_q})
                               : {1'b0, acc_hi};

    // Divide: acc_hi is the remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, mag_b_q});
    assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_lo : acc_lo;
    assign rem_fix  = neg_a_q ? -acc_hi : acc_hi;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_div_q    <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            a_q         <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div_q    <= op[1];
                        neg_a_q     <= in_neg_a;
                        neg_b_q     <= in_neg_b;
                        b_zero_q    <= (b == '0);
                        a_q         <= a;
                        mag_a_q     <= in_mag_a;
                        mag_b_q     <= in_mag_b;
                        acc_hi      <= '0;
                        acc_lo      <= op[1] ? in_mag_a : in_mag_b;
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                    end else if (move_to) begin
                        if (op[0]) begin
                            lo <= a;
                        end else begin
                            hi <= a;
                        end
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div_q) begin
                        acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (!is_div_q) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (b_zero_q) begin
                        hi          <= a_q;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32).
// Random and directed operations against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dz;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    function automatic void model(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] h,
                                  output logic [31:0] l, output logic d);
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] up;
        sx = x;
        sy = y;
        d  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            3'd0: begin
                sp = longint'(sx) * longint'(sy);
                {h, l} = sp;
            end
            3'd1: begin
                ux = {32'b0, x};
                uy = {32'b0, y};
                up = ux * uy;
                {h, l} = up;
            end
            default: begin
                if (y == 32'h0) begin
                    h = x;
                    l = 32'hFFFF_FFFF;
                    d = 1'b1;
                end else if (o == 3'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    h = 32'h0;
                    l = 32'h8000_0000;
                end else if (o == 3'd2) begin
                    l = sx / sy;
                    h = sx % sy;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        int          edges;
        bit          calc_bad;
        model(o, x, y, eh, el, ed);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", tag, busy, done);
        end
        edges    = 0;
        calc_bad = 0;
        while (edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            if (done === 1'b1) break;
            if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) calc_bad = 1;
        end
        checks++;
        if (calc_bad) begin
            errors++;
            $display("FAIL %s calc_hold: busy/hi/lo changed during CALC (hi=%h lo=%h want %h %h)",
                     tag, hi, lo, m_hi, m_lo);
        end
        checks++;
        if (edges != W + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", tag, edges, W + 1);
        end
        checks++;
        if (hi !== eh || lo !== el || div_by_zero !== ed || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h dz=%b busy=%b want hi=%h lo=%h dz=%b busy=0",
                     tag, hi, lo, div_by_zero, busy, eh, el, ed);
        end
        m_hi = eh;
        m_lo = el;
        m_dz = ed;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        a     = 32'd5;
        b     = 32'd5;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
                     busy, done, div_by_zero, hi, lo);
        end
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        m_dz  = 1'b0;
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, "mult_neg3x5");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, "div_7_neg2");
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, "div_by_zero_s");
        run_op(3'd3, 32'h0000_0007, 32'h0000_0000, "divu_by_zero");
    endtask

    task automatic test_mt();
        logic [31:0] v;
        logic [31:0] save_hi;
        logic [31:0] save_lo;
        v = $urandom;
        @(negedge clock);
        start = 1'b1;
        op    = 3'd4;
        a     = v;
        @(posedge clock);
        #1;
        start = 1'b0;
        m_hi  = v;
        checks++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b dz=%b want hi=%h lo=%h 0 0 0",
                     hi, lo, busy, done, div_by_zero, m_hi, m_lo);
        end
        m_dz = 1'b0;
        v = $urandom;
        @(negedge clock);
        start = 1'b1;
        op    = 3'd5;
        a     = v;
        @(posedge clock);
        #1;
        start = 1'b0;
        m_lo  = v;
        checks++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
                     hi, lo, busy, m_hi, m_lo);
        end
        save_hi = m_hi;
        save_lo = m_lo;
        for (int k = 6; k < 8; k++) begin
            @(negedge clock);
            start = 1'b1;
            op    = 3'(k);
            a     = $urandom;
            b     = $urandom;
            @(posedge clock);
            #1;
            start = 1'b0;
            repeat (2) @(posedge clock);
            #1;
            checks++;
            if (hi !== save_hi || lo !== save_lo || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reserved_op%0d: hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h 0 0",
                         k, hi, lo, busy, done, save_hi, save_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, $urandom, $urandom, "b2b_mult");
        run_op(3'd3, $urandom, 32'($urandom_range(1, 1000)), "b2b_divu");
        run_op(3'd2, $urandom, $urandom, "b2b_div");
        run_op(3'd1, $urandom, $urandom, "b2b_multu");
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: x = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                3: y = 32'($urandom_range(1, 15));
                4: begin
                    x = 32'h8000_0000;
                    y = 32'hFFFF_FFFF;
                end
                default: ;
            endcase
            run_op(o, x, y, $sformatf("rand%0d_op%0d", i, o));
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        @(negedge clock);
        start = 1'b1;
        op    = 3'd1;
        a     = 32'd2;
        b     = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd9;
        b     = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL abort_busy_start: busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                     busy, hi, lo, m_hi, m_lo);
        end
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: hi=%h lo=%h busy=%b done=%b dz=%b want all zero",
                     hi, lo, busy, done, div_by_zero);
        end
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy !== 1'b0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: done or busy seen after reset, want none");
        end
        @(negedge clock);
        start = 1'b1;
        op    = 3'd5;
        a     = 32'h1234_5678;
        @(posedge clock);
        #1;
        start = 1'b0;
        m_lo  = 32'h1234_5678;
        checks++;
        if (lo !== m_lo || hi !== m_hi || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_mtlo: lo=%h hi=%h busy=%b want lo=%h hi=%h busy=0",
                     lo, hi, busy, m_lo, m_hi);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        m_hi  = '0;
        m_lo  = '0;
        m_dz  = 1'b0;
        test_reset();
        test_directed();
        test_mt();
        test_back_to_back();
        test_random();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width and the width of the HI and LO registers (legal range 8..64).
REQ-002 The module SHALL have port clock, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, a synchronous, active-high reset sampled on the rising edge of clock.
REQ-004 The module SHALL have port start, input, 1 bit, a request strobe sampled on the rising edge.
REQ-005 The module SHALL have port op, input, 3 bits, the operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 The module SHALL have port a, input, WIDTH bits, operand 1 (multiplicand, dividend, or MTHI/MTLO data).
REQ-007 The module SHALL have port b, input, WIDTH bits, operand 2 (multiplier or divisor).
REQ-008 The module SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 The module SHALL have port done, output, 1 bit, a one-cycle pulse when HI/LO are updated by MULT/MULTU/DIV/DIVU.
REQ-010 The module SHALL have port div_by_zero, output, 1 bit, registered with done and held until the next accepted start.
REQ-011 The module SHALL have port hi, output, WIDTH bits, the HI register.
REQ-012 The module SHALL have port lo, output, WIDTH bits, the LO register.

Function
REQ-013 The module SHALL implement FSM states IDLE, CALC and FIX, with an iteration counter of clog2(WIDTH+1) bits.
REQ-014 With E0 the edge that samples start=1 in IDLE with op in 000..011, the module SHALL latch a, b and op at E0, enter CALC, set busy=1 and load the counter with WIDTH.
REQ-015 In CALC the module SHALL perform one iteration per edge, E1..E_WIDTH: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes; after E_WIDTH it SHALL enter FIX.
REQ-016 At E_(WIDTH+1) (the FIX edge) the module SHALL apply sign correction, write hi/lo, set done=1 and busy=0, and return to IDLE.
REQ-017 done SHALL return to 0 on the next edge, so it is high for exactly one cycle.
REQ-018 Total latency SHALL be WIDTH+1 edges from E0 to the hi/lo update.
REQ-019 hi and lo SHALL hold their previous values throughout CALC.
REQ-020 MULT SHALL be a signed 2*WIDTH product and MULTU an unsigned one, with {hi,lo} = product.
REQ-021 DIV SHALL be signed: lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
REQ-022 DIVU SHALL be unsigned: lo = quotient, hi = remainder.
REQ-023 Signed overflow (most-negative / -1) SHALL give lo = most-negative and hi = 0, with div_by_zero=0.
REQ-024 Division with b=0 SHALL still take the full WIDTH+1 latency and then set lo = all ones, hi = a, and div_by_zero=1.
REQ-025 MTHI (MTLO) accepted in IDLE SHALL write a into hi (lo) at E0 without changing state, busy, or done, and SHALL clear div_by_zero.
REQ-026 start while busy=1, or with a reserved op, SHALL be ignored with no state change.
REQ-027 Operand inputs SHALL be don't-care after E0; only the latched copies are used.
REQ-028 Back-to-back operation SHALL be supported: start=1 in the cycle done=1 (state IDLE) SHALL be accepted at that edge.

Reset
REQ-029 When reset=1 at an edge, the module SHALL, in any state including mid-CALC, go to IDLE and set busy=0, done=0, div_by_zero=0, hi=0, lo=0, and counter=0.
REQ-030 reset SHALL take priority over start at the same edge.
REQ-031 An operation interrupted by reset SHALL produce no done pulse.

Verification (WIDTH=32)
REQ-032 MULT a=FFFFFFFD (-3), b=00000005 -> after 33 edges: done pulse, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-033 MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high for exactly 33 cycles.
REQ-034 DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-035 DIVU a=00000007, b=0 -> done after 33 edges, div_by_zero=1, hi=00000007, lo=FFFFFFFF.
REQ-036 Start MULTU 2x3; at E5 apply start with DIV 9/3, which is ignored; at E10 assert reset -> hi=lo=0, busy=0, and no done; then MTLO a=12345678 -> lo=12345678 the next cycle and busy stays 0.
